fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 117 +++++++++++
 tb/tb_fetch_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: walks a 16-bit program counter, requests one word at a
// time from instruction memory, holds it for the decode stage until consumed,
// and raises a sticky error if memory never answers. A redirect from execute
// overrides everything except the initial IDLE cycle.
module fetch_unit #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int          WAIT_LIMIT = 15
) (
  input  logic        clock,
  input  logic        rst,
  output logic [15:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  input  logic        jump,
  input  logic [15:0] jump_addr,
  input  logic        stall,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  output logic        fetch_err
);

  // Counter only needs to reach WAIT_LIMIT; keep at least one bit when disabled.
  localparam int          CW       = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [CW-1:0] WAIT_MAX = CW'(WAIT_LIMIT);
  localparam bit          TIMEOUT_EN = (WAIT_LIMIT > 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     pc_q, pc_d;
  logic [15:0]     instr_q, instr_d;
  logic [15:0]     instr_pc_q, instr_pc_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;

  // State register; reset takes effect immediately, independent of the clock.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= 16'h0000;
      instr_pc_q <= 16'h0000;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state logic: a redirect outside IDLE beats capture, stall and timeout.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    wait_cnt_d = wait_cnt_q;

    if (jump && (state_q != IDLE)) begin
      // Any in-flight data or held word is dropped; the error flag clears.
      pc_d       = jump_addr;
      wait_cnt_d = '0;
      state_d    = FETCH;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = FETCH;
        end
        FETCH: begin
          if (imem_ack) begin
            instr_d    = imem_data;
            instr_pc_d = pc_q;
            pc_d       = pc_q + 16'd1;   // wraps 16'hFFFF -> 16'h0000
            wait_cnt_d = '0;
            state_d    = HOLD;
          end else if (TIMEOUT_EN) begin
            if (wait_cnt_q == WAIT_MAX) begin
              state_d = ERR;
            end else begin
              wait_cnt_d = wait_cnt_q + CW'(1);
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            state_d = FETCH;
          end
        end
        ERR: begin
          state_d = ERR;                 // pc frozen until redirect or reset
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Outputs are pure decodes of the registered state, so they follow reset at once.
  always_comb begin
    imem_addr   = pc_q;
    imem_req    = (state_q == FETCH);
    instr_valid = (state_q == HOLD);
    fetch_err   = (state_q == ERR);
    instr       = instr_q;
    instr_pc    = instr_pc_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a simple memory model answers requests, the
// stimulus process pushes expected consumed instructions into a scoreboard and
// a monitor pops/compares on every consumption edge.
`timescale 1ns/1ps
module tb_fetch_unit;

  logic        clock;
  logic        rst;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        jump;
  logic [15:0] jump_addr;
  logic        stall;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        fetch_err;

  logic ack_en;
  logic ack_force;
  logic dead_en;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [15:0] word;
    logic [15:0] pc;
  } exp_t;
  exp_t exp_q[$];

  fetch_unit #(.RESET_PC(16'h0000), .WAIT_LIMIT(15)) dut (
    .clock       (clock),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_req    (imem_req),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .jump        (jump),
    .jump_addr   (jump_addr),
    .stall       (stall),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .fetch_err   (fetch_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Memory model: zero-wait ack while enabled; data is 16'hA000 + address.
  assign imem_ack  = ack_force | (ack_en & imem_req);
  assign imem_data = dead_en ? 16'hDEAD : (16'hA000 + imem_addr);

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("[TB] pass %s: %h (t=%0t)", name, act, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Monitor: the word is consumed at the next edge when valid, not stalled, not redirected.
  always @(negedge clock) begin
    if (!rst && instr_valid && !stall && !jump) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected consume: got %h@%h, expected none", instr, instr_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("consume instr", instr, e.word);
        check("consume instr_pc", instr_pc, e.pc);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running, expected finish");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; jump = 1'b0; jump_addr = 16'h0000; stall = 1'b0;
    ack_en = 1'b0; ack_force = 1'b0; dead_en = 1'b0;

    // Reset state
    #2;
    check("rst imem_req", {15'd0, imem_req}, 16'd0);
    check("rst imem_addr", imem_addr, 16'h0000);
    check("rst instr_valid", {15'd0, instr_valid}, 16'd0);
    check("rst fetch_err", {15'd0, fetch_err}, 16'd0);
    check("rst instr", instr, 16'h0000);
    check("rst instr_pc", instr_pc, 16'h0000);
    #10;
    rst = 1'b0;
    check("idle no req", {15'd0, imem_req}, 16'd0);
    step();
    check("first req", {15'd0, imem_req}, 16'd1);
    check("first addr", imem_addr, 16'h0000);

    // Back-to-back fetches, one instruction every two cycles
    ack_en = 1'b1;
    exp_q.push_back('{16'hA000, 16'h0000});
    exp_q.push_back('{16'hA001, 16'h0001});
    exp_q.push_back('{16'hA002, 16'h0002});
    exp_q.push_back('{16'hA003, 16'h0003});
    for (int i = 0; i < 6; i++) begin
      step();
      check("valid cadence", {15'd0, instr_valid}, (i % 2 == 0) ? 16'd1 : 16'd0);
    end
    check("fetch addr 3", imem_addr, 16'h0003);

    // Stall in HOLD for five cycles
    stall = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      check("stall valid", {15'd0, instr_valid}, 16'd1);
      check("stall instr", instr, 16'hA003);
      check("stall no req", {15'd0, imem_req}, 16'd0);
      if (i != 4) step();
    end
    stall = 1'b0;
    step();
    check("post-stall req", {15'd0, imem_req}, 16'd1);
    check("post-stall addr", imem_addr, 16'h0004);

    // Jump coincident with ack discards the data
    jump = 1'b1; jump_addr = 16'h0100; dead_en = 1'b1;
    step();
    jump = 1'b0; dead_en = 1'b0; ack_en = 1'b0;
    check("jump+ack instr", instr, 16'hA003);
    check("jump+ack instr_pc", instr_pc, 16'h0003);
    check("jump+ack valid", {15'd0, instr_valid}, 16'd0);
    check("jump+ack addr", imem_addr, 16'h0100);

    // Timeout: 16 FETCH cycles without ack
    repeat (15) step();
    check("15 waits no err", {15'd0, fetch_err}, 16'd0);
    check("15 waits req", {15'd0, imem_req}, 16'd1);
    step();
    check("timeout err", {15'd0, fetch_err}, 16'd1);
    check("timeout no req", {15'd0, imem_req}, 16'd0);
    check("timeout valid", {15'd0, instr_valid}, 16'd0);
    step();
    check("err sticky", {15'd0, fetch_err}, 16'd1);
    check("err pc frozen", imem_addr, 16'h0100);
    jump = 1'b1; jump_addr = 16'h0020;
    step();
    check("err exit flag", {15'd0, fetch_err}, 16'd0);
    check("err exit addr", imem_addr, 16'h0020);
    check("err exit req", {15'd0, imem_req}, 16'd1);

    // pc wrap at 16'hFFFF
    jump_addr = 16'hFFFF;
    step();
    jump = 1'b0; ack_en = 1'b1;
    exp_q.push_back('{16'h9FFF, 16'hFFFF});
    check("wrap fetch addr", imem_addr, 16'hFFFF);
    step();
    check("wrap next addr", imem_addr, 16'h0000);
    check("wrap valid", {15'd0, instr_valid}, 16'd1);
    step();
    check("wrap refetch req", {15'd0, imem_req}, 16'd1);
    step();
    check("hold instr", instr, 16'hA000);
    check("hold instr_pc", instr_pc, 16'h0000);

    // Jump in HOLD while stalled drops the held word
    stall = 1'b1; jump = 1'b1; jump_addr = 16'h0200; ack_en = 1'b0;
    step();
    check("hold jump valid", {15'd0, instr_valid}, 16'd0);
    check("hold jump addr", imem_addr, 16'h0200);
    check("hold jump instr", instr, 16'hA000);

    // Asynchronous reset mid-FETCH at 16'h0042, then a late ack
    jump_addr = 16'h0042; stall = 1'b0;
    step();
    jump = 1'b0;
    check("pre-rst addr", imem_addr, 16'h0042);
    #2;
    rst = 1'b1;
    #1;
    check("async rst addr", imem_addr, 16'h0000);
    check("async rst req", {15'd0, imem_req}, 16'd0);
    check("async rst instr", instr, 16'h0000);
    check("async rst valid", {15'd0, instr_valid}, 16'd0);
    #2;
    rst = 1'b0; ack_force = 1'b1;
    step();
    ack_force = 1'b0;
    check("late ack req", {15'd0, imem_req}, 16'd1);
    check("late ack valid", {15'd0, instr_valid}, 16'd0);
    check("late ack instr", instr, 16'h0000);
    step();
    check("scoreboard drained", 16'(exp_q.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
